// File: rtl/mdu.sv
// rtl/mdu.sv - iterative 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO
// The divider datapath is built only when MDU_DIV_EN is defined.
module mdu #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [WORD_WIDTH-1:0] opA,
  input  logic [WORD_WIDTH-1:0] opB,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] hi,
  output logic [WORD_WIDTH-1:0] lo
);
  localparam int W  = WORD_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_e;
  state_e state_q, state_d;

  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic           busy_q, busy_d, done_q, done_d;
`ifdef MDU_DIV_EN
  logic           is_div_q, is_div_d, divz_q, divz_d, neg_rem_q, neg_rem_d;
  logic [W:0]     rem_sh, rem_sub;
`else
  logic           skip_q, skip_d;
`endif

  logic           is_mul_op, is_div_op, sign_op;
  logic [W-1:0]   a_mag, b_mag, addend;
  logic [W:0]     add_sum;
  logic [2*W-1:0] prod_neg;

  assign is_mul_op = (op[2:1] == 2'b00);
  assign is_div_op = (op[2:1] == 2'b01);
  assign sign_op   = ~op[0];
  // Iterations run on magnitudes; signs are restored at FIN.
  assign a_mag = (sign_op && opA[W-1]) ? (~opA + 1'b1) : opA;
  assign b_mag = (sign_op && opB[W-1]) ? (~opB + 1'b1) : opB;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q  <= 1'b0;
      divz_q    <= 1'b0;
      neg_rem_q <= 1'b0;
`else
      skip_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef MDU_DIV_EN
      is_div_q  <= is_div_d;
      divz_q    <= divz_d;
      neg_rem_q <= neg_rem_d;
`else
      skip_q    <= skip_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && is_mul_op) begin
          state_d = S_RUN;
        end else if (start && is_div_op) begin
`ifdef MDU_DIV_EN
          state_d = S_RUN;
`else
          state_d = S_FIN;
`endif
        end
      end
      S_RUN:   if (cnt_q == CW'(W - 1)) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    // A divide that skips straight to FIN (no divider built) never raises busy.
    busy_d  = (state_d == S_RUN) || (state_d == S_FIN && state_q == S_RUN);
    addend  = b_q[0] ? a_q : '0;
    add_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, addend};
    prod_neg = ~acc_q + 1'b1;
`ifdef MDU_DIV_EN
    is_div_d  = is_div_q;
    divz_d    = divz_q;
    neg_rem_d = neg_rem_q;
    rem_sh    = {acc_q[2*W-1:W], a_q[W-1]};
    rem_sub   = rem_sh - {1'b0, b_q};
`else
    skip_d    = skip_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && (is_mul_op || is_div_op)) begin
          a_d   = a_mag;
          b_d   = b_mag;
          acc_d = '0;
          cnt_d = '0;
          neg_d = sign_op && (opA[W-1] ^ opB[W-1]);
`ifdef MDU_DIV_EN
          is_div_d  = is_div_op;
          divz_d    = (opB == '0);
          neg_rem_d = sign_op && opA[W-1];
`else
          skip_d    = is_div_op;
`endif
        end else if (start && op == OP_MTHI) begin
          hi_d = opA;
        end else if (start && op == OP_MTLO) begin
          lo_d = opA;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          // Upper half holds the partial remainder, lower half collects quotient bits.
          a_d = a_q << 1;
          if (!rem_sub[W]) acc_d = {rem_sub[W-1:0], acc_q[W-2:0], 1'b1};
          else             acc_d = {rem_sh[W-1:0],  acc_q[W-2:0], 1'b0};
        end else
`endif
        begin
          b_d   = b_q >> 1;
          acc_d = {add_sum, acc_q[W-1:1]};
        end
      end
      S_FIN: begin
        done_d = 1'b1;
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          lo_d = divz_q ? '1 : (neg_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0]);
          hi_d = neg_rem_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : acc_q;
        end
`else
        if (!skip_q) {hi_d, lo_d} = neg_q ? prod_neg : acc_q;
`endif
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - scoreboard bench for mdu (directed cases plus random ops vs arithmetic model)
module tb_mdu;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] opA = '0, opB = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  mdu #(.WORD_WIDTH(32)) dut (
    .clk(clk), .nrst(nrst), .start(start), .op(op), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    longint unsigned up;
    int q, r;
    case (o)
      3'b000: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp; end
      3'b001: begin up = {32'b0, a} * {32'b0, b}; return up; end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (o == 3'b011) return {a % b, a / b};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (nrst && done) begin
      if (exp_q.size() == 0) check("done with empty scoreboard", {63'b0, done}, 64'd0);
      else check("hi/lo result", {hi, lo}, exp_q.pop_front());
    end
  end

  // Called just after a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [63:0] e;
    logic [31:0] h0, l0;
    bit iter, stable;
    int n, bcnt;
    iter = (o[2:1] == 2'b00) || (o[2:1] == 2'b01 && DIV_EN);
    e = iter ? model(o, a, b) : {m_hi, m_lo};
    exp_q.push_back(e);
    h0 = m_hi; l0 = m_lo;
    {m_hi, m_lo} = e;
    start = 1'b1; op = o; opA = a; opB = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom_range(0, 7)); opA = $urandom; opB = $urandom;
    n = 0; bcnt = 0; stable = 1'b1;
    while (n < 60) begin
      @(negedge clk); n++;
      if (start) start = 1'b0;
      if (poke && n == 5) begin
        start = 1'b1; op = 3'($urandom_range(0, 7)); opA = $urandom; opB = $urandom;
      end
      if (done) break;
      if (busy) bcnt++;
      if (hi !== h0 || lo !== l0) stable = 1'b0;
    end
    start = 1'b0;
    check("done latency", 64'(n - 1), iter ? 64'd33 : 64'd1);
    check("busy cycles", 64'(bcnt), iter ? 64'd33 : 64'd0);
    check("busy low at done", {63'b0, busy}, 64'd0);
    check("hi/lo held while running", {63'b0, stable}, 64'd1);
  endtask

  task automatic mt(input bit is_lo, input logic [31:0] a);
    start = 1'b1; op = is_lo ? 3'b101 : 3'b100; opA = a; opB = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    if (is_lo) m_lo = a; else m_hi = a;
    check("mthi/mtlo hi", {32'b0, hi}, {32'b0, m_hi});
    check("mthi/mtlo lo", {32'b0, lo}, {32'b0, m_lo});
    @(negedge clk);
    check("mthi/mtlo busy/done", {62'b0, busy, done}, 64'd0);
  endtask

  initial begin
    int dn;
    logic [2:0] o;
    repeat (2) @(negedge clk);
    check("reset busy/done", {62'b0, busy, done}, 64'd0);
    check("reset hi/lo", {hi, lo}, 64'd0);
    nrst = 1'b1;
    @(negedge clk);

    run_op(3'b000, 32'hFFFFFFFD, 32'd7, 1'b0);
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(3'b010, -32'sd7, 32'd2, 1'b0);
    run_op(3'b011, 32'd100, 32'd7, 1'b0);
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(3'b011, 32'd5, 32'd0, 1'b0);
    run_op(3'b010, -32'sd9, 32'd0, 1'b0);
    run_op(3'b010, 32'd9, 32'd3, 1'b0);
    run_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    run_op(3'b000, 32'h8000_0000, 32'h8000_0000, 1'b1);
    mt(1'b0, 32'hA5A5A5A5);
    mt(1'b1, 32'h5A5A0001);

    // Reserved op must be ignored.
    start = 1'b1; op = 3'b110; opA = $urandom; opB = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("reserved op hi/lo", {hi, lo}, {m_hi, m_lo});
    check("reserved op busy/done", {62'b0, busy, done}, 64'd0);

    // Reset in the middle of a MULTU: result is discarded.
    start = 1'b1; op = 3'b001; opA = $urandom; opB = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check("mid-op reset busy/done", {62'b0, busy, done}, 64'd0);
    check("mid-op reset hi/lo", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    nrst = 1'b1;
    dn = 0;
    repeat (45) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("no activity after reset", 64'(dn), 64'd0);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 5));
      if (o[2]) mt(o[0], pick());
      else run_op(o, pick(), pick(), ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(negedge clk);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mdu.md
# mdu

Sequential multiply/divide unit for the 32-bit MIPS-style datapath. It sits directly downstream of the register file's read ports and takes its operands from `rd_dataA`/`rd_dataB`. It computes MULT/MULTU/DIV/DIVU iteratively over 32 cycles into architectural HI/LO registers, and also accepts MTHI/MTLO writes. HI/LO are read back by the writeback path (MFHI/MFLO), and `busy` stalls issue while an operation is in flight.

## Interface
- `WORD_WIDTH`, 32: operand and result width; only 32 is verified.
- `clk`  in  1  rising-edge clock
- `nrst`  in  1  asynchronous active-low reset
- `start`  in  1  issue request; sampled on the rising edge of `clk`
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
- `opA`  in  32  rs value (multiplicand/dividend; MTHI/MTLO source)
- `opB`  in  32  rt value (multiplier/divisor)
- `busy`  out  1  iterative operation in flight
- `done`  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE, `start`=1, op is MULT/MULTU/DIV/DIVU:
  - latch operands (magnitudes if signed) and the result-sign flags;
  - clear the 64-bit accumulator and the 5-bit count;
  - go to RUN.
- IDLE, `start`=1, MTHI/MTLO: `hi`/`lo` <= `opA` on that edge; stay in IDLE; no `busy`, no `done`.
- Reserved op, or `start` while not IDLE: ignored, with no state change.
- RUN: one iteration per cycle.
  - Multiply: shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring, one quotient bit per cycle, MSB first.
  - After count 31 go to FIN.
- FIN: apply sign fix-up, write HI/LO, pulse `done`, return to IDLE.
- Multiply results: {hi,lo} = 64-bit product. MULT is signed two's complement; MULTU is unsigned.
- Divide results: lo = quotient, hi = remainder.
  - DIV truncates toward zero; the remainder takes the dividend's sign.
  - DIVU is unsigned.
- Divide by zero, either DIV or DIVU: full latency; lo = 32'hFFFFFFFF, hi = dividend, unmodified.
- DIV 32'h80000000 / 32'hFFFFFFFF: lo = 32'h80000000, hi = 0. No trap.
- Operands are latched at issue; `opA`/`opB` may change while busy.
- `hi`/`lo` hold their old values throughout RUN and change only at FIN or on MTHI/MTLO.

## Timing
- Reset (async, `nrst`=0): `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, count 0. Takes effect immediately, including mid-operation; the in-flight result is discarded.
- Issue edge E0 starts the operation.
- `busy`=1 from E0 through the cycle before FIN completes, i.e. high for 33 cycles.
- At edge E33:
  - `hi`/`lo` take the result;
  - `done` rises for one cycle;
  - `busy` falls on the same edge.
- A new `start` is accepted at E33 if the FSM is IDLE. Back-to-back throughput is one op per 34 edges.
- MTHI/MTLO: one-edge latency; also legal on the edge `done` pulses.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MDU_DIV_EN` defined: DIV/DIVU behave as above.
- `MDU_DIV_EN` undefined: no divider datapath is built.
  - DIV/DIVU are accepted from IDLE but do not raise `busy`.
  - `done` pulses on the edge after issue; `hi`/`lo` stay unchanged.
  - The pipeline never deadlocks.
- Multiply and MTHI/MTLO are identical in both builds.

## Test plan
- Reset mid-op: MULTU issued, `nrst` pulsed low at cycle 10 -> `busy`=0, `done`=0, `hi`=`lo`=0 immediately. No `done` follows.
- MULT opA=32'hFFFFFFFD (-3), opB=7 -> `done` at E33; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB. MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
- DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 32'h80000000/32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- DIVU 5/0 -> after 33 cycles lo=32'hFFFFFFFF, hi=5.
- `start` with new operands while busy -> ignored; result matches the first operands. MTHI 32'hA5A5A5A5 in IDLE -> hi updates next edge, lo unchanged, `done` stays 0.
- Build without `MDU_DIV_EN`: DIV 9/3 -> `busy` never rises, `done` one edge after issue, hi/lo unchanged.
